instr_fetch_mem: RTL and testbench

//  Instruction-memory responder on the PC's fetch interface: takes the PC address each cycle and returns
//  the instruction into the IM/ID pipe register one clock later.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/im_ram.sv | 28 ++
 rtl/instr_fetch_mem.sv | 94 +++++++++
 tb/tb_instr_fetch_mem.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch-stage state type.
package cpu_pkg;

  localparam int unsigned ADDR_W   = 17;
  localparam int unsigned DEPTH_LG = 14;
  localparam int unsigned INSTR_W  = 16;

  localparam logic [15:0] NOP_INSTR = 16'hF000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/im_ram.sv
// Instruction RAM: one write port (loader), one synchronous read port (fetch).
// Separate ports and an unreset read register keep this block-RAM friendly.
module im_ram #(
  parameter int unsigned DEPTH_LG = 14,
  parameter int unsigned INSTR_W  = 16
) (
  input  logic                clk,
  input  logic                re,
  input  logic [DEPTH_LG-1:0] raddr,
  output logic [INSTR_W-1:0]  rdata,
  input  logic                we,
  input  logic [DEPTH_LG-1:0] waddr,
  input  logic [INSTR_W-1:0]  wdata
);

  logic [INSTR_W-1:0] mem [0:(1 << DEPTH_LG)-1];

  // Loader write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Fetch read port; holding re low freezes the last word read.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: 1-cycle fetch into the IM/ID pipe register with
// stall hold, wrong-path squash, range check and a boot-loader write port.
module instr_fetch_mem #(
  parameter int unsigned ADDR_W   = cpu_pkg::ADDR_W,
  parameter int unsigned DEPTH_LG = cpu_pkg::DEPTH_LG,
  parameter int unsigned INSTR_W  = cpu_pkg::INSTR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   pc,
  input  logic                stall_IM_ID,
  input  logic                flow_change_ID_EX,
  input  logic                prog_mode,
  input  logic                prog_we,
  input  logic [DEPTH_LG-1:0] prog_addr,
  input  logic [INSTR_W-1:0]  prog_data,
  output logic [INSTR_W-1:0]  instr_IM_ID,
  output logic                instr_vld,
  output logic                fetch_err
);

  import cpu_pkg::*;

  fetch_state_t       state, state_nxt;
  logic               fetch;
  logic               ram_we;
  logic               out_of_range;
  logic               pass_q;
  logic               err_q;
  logic [INSTR_W-1:0] ram_rdata;

  assign out_of_range = |pc[ADDR_W-1:DEPTH_LG];

  im_ram #(
    .DEPTH_LG (DEPTH_LG),
    .INSTR_W  (INSTR_W)
  ) u_ram (
    .clk   (clk),
    .re    (!stall_IM_ID),
    .raddr (pc[DEPTH_LG-1:0]),
    .rdata (ram_rdata),
    .we    (ram_we),
    .waddr (prog_addr),
    .wdata (prog_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  // Next state, fetch qualification and loader write strobe.
  always_comb begin
    state_nxt = state;
    fetch     = 1'b0;
    ram_we    = 1'b0;
    case (state)
      BOOT: state_nxt = prog_mode ? LOAD : RUN;
      RUN: begin
        if (prog_mode) state_nxt = LOAD;
        else           fetch     = !flow_change_ID_EX;
      end
      LOAD: begin
        ram_we = prog_mode && prog_we;
        if (!prog_mode) state_nxt = BOOT;
      end
      default: state_nxt = BOOT;
    endcase
    // A stall freezes the whole stage, including any pending redirect.
    if (stall_IM_ID) begin
      state_nxt = state;
      fetch     = 1'b0;
    end
  end

  // Valid flag: marks whether the RAM word read at this edge is a real fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            pass_q <= 1'b0;
    else if (!stall_IM_ID) pass_q <= fetch && !out_of_range;
  end

  // Sticky out-of-range fetch flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     err_q <= 1'b0;
    else if (fetch && out_of_range) err_q <= 1'b1;
  end

  // RAM output register doubles as the pipe register; invalid cycles show a NOP.
  assign instr_IM_ID = pass_q ? ram_rdata : INSTR_W'(NOP_INSTR);
  assign instr_vld   = pass_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed, table-driven bench for instr_fetch_mem.
module tb_instr_fetch_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [16:0] pc;
  logic        stall_IM_ID;
  logic        flow_change_ID_EX;
  logic        prog_mode;
  logic        prog_we;
  logic [13:0] prog_addr;
  logic [15:0] prog_data;
  logic [15:0] instr_IM_ID;
  logic        instr_vld;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] NOP = 16'hF000;

  typedef struct {
    string       name;
    logic [16:0] pc;
    logic        stall;
    logic        flow;
    logic        pm;
    logic        we;
    logic [13:0] addr;
    logic [15:0] data;
    logic [15:0] exp_instr;
    logic        exp_vld;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  logic [15:0] rel_exp [5] = '{16'hF000, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic        rel_vld [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  instr_fetch_mem #(
    .ADDR_W   (17),
    .DEPTH_LG (14),
    .INSTR_W  (16)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pc                (pc),
    .stall_IM_ID       (stall_IM_ID),
    .flow_change_ID_EX (flow_change_ID_EX),
    .prog_mode         (prog_mode),
    .prog_we           (prog_we),
    .prog_addr         (prog_addr),
    .prog_data         (prog_data),
    .instr_IM_ID       (instr_IM_ID),
    .instr_vld         (instr_vld),
    .fetch_err         (fetch_err)
  );

  always #5 clk = ~clk;

  function automatic void add(string n, logic [16:0] p, logic st, logic fl, logic pm,
                              logic we, logic [13:0] a, logic [15:0] d,
                              logic [15:0] ei, logic ev, logic ee);
    vec_t v;
    v.name = n; v.pc = p; v.stall = st; v.flow = fl; v.pm = pm; v.we = we;
    v.addr = a; v.data = d; v.exp_instr = ei; v.exp_vld = ev; v.exp_err = ee;
    vecs.push_back(v);
  endfunction

  task automatic chk(string n, logic [15:0] ei, logic ev, logic ee);
    checks++;
    if (instr_IM_ID !== ei || instr_vld !== ev || fetch_err !== ee) begin
      errors++;
      $display("FAIL %s: got instr=%h vld=%b err=%b, expected instr=%h vld=%b err=%b",
               n, instr_IM_ID, instr_vld, fetch_err, ei, ev, ee);
    end
  endtask

  task automatic drive(logic [16:0] p, logic st, logic fl, logic pm, logic we,
                       logic [13:0] a, logic [15:0] d);
    pc = p; stall_IM_ID = st; flow_change_ID_EX = fl;
    prog_mode = pm; prog_we = we; prog_addr = a; prog_data = d;
  endtask

  initial begin
    //   name            pc        st fl pm we addr      data      instr     vld err
    add("boot_to_load",  17'h0,    0, 0, 1, 0, 14'h0,    16'h0,    NOP,      0, 0);
    add("load_w0",       17'h0,    0, 0, 1, 1, 14'h0,    16'h1111, NOP,      0, 0);
    add("load_w1",       17'h0,    0, 0, 1, 1, 14'h1,    16'h2222, NOP,      0, 0);
    add("load_w2",       17'h0,    0, 0, 1, 1, 14'h2,    16'h3333, NOP,      0, 0);
    add("load_w3",       17'h0,    0, 0, 1, 1, 14'h3,    16'h4444, NOP,      0, 0);
    add("load_wtop",     17'h0,    0, 0, 1, 1, 14'h3FFF, 16'h7E7E, NOP,      0, 0);
    add("load_exit",     17'h0,    0, 0, 0, 0, 14'h0,    16'h0,    NOP,      0, 0);
    add("boot_nop",      17'h0,    0, 0, 0, 0, 14'h0,    16'h0,    NOP,      0, 0);
    add("fetch0",        17'h0,    0, 0, 0, 0, 14'h0,    16'h0,    16'h1111, 1, 0);
    add("fetch1",        17'h1,    0, 0, 0, 0, 14'h0,    16'h0,    16'h2222, 1, 0);
    add("stall1",        17'h2,    1, 0, 0, 0, 14'h0,    16'h0,    16'h2222, 1, 0);
    add("stall2",        17'h2,    1, 0, 0, 0, 14'h0,    16'h0,    16'h2222, 1, 0);
    add("stall3",        17'h2,    1, 0, 0, 0, 14'h0,    16'h0,    16'h2222, 1, 0);
    add("stall_rel",     17'h2,    0, 0, 0, 0, 14'h0,    16'h0,    16'h3333, 1, 0);
    add("fetch3",        17'h3,    0, 0, 0, 0, 14'h0,    16'h0,    16'h4444, 1, 0);
    add("squash3",       17'h3,    0, 1, 0, 0, 14'h0,    16'h0,    NOP,      0, 0);
    add("redirect0",     17'h0,    0, 0, 0, 0, 14'h0,    16'h0,    16'h1111, 1, 0);
    add("fetch1b",       17'h1,    0, 0, 0, 0, 14'h0,    16'h0,    16'h2222, 1, 0);
    add("stall_flow",    17'h2,    1, 1, 0, 0, 14'h0,    16'h0,    16'h2222, 1, 0);
    add("flow_after",    17'h2,    0, 1, 0, 0, 14'h0,    16'h0,    NOP,      0, 0);
    add("fetch3b",       17'h3,    0, 0, 0, 0, 14'h0,    16'h0,    16'h4444, 1, 0);
    add("squash0",       17'h0,    0, 1, 0, 0, 14'h0,    16'h0,    NOP,      0, 0);
    add("stall_on_nop",  17'h0,    1, 0, 0, 0, 14'h0,    16'h0,    NOP,      0, 0);
    add("fetch0b",       17'h0,    0, 0, 0, 0, 14'h0,    16'h0,    16'h1111, 1, 0);
    add("top_in_range",  17'h3FFF, 0, 0, 0, 0, 14'h0,    16'h0,    16'h7E7E, 1, 0);
    add("oor_squashed",  17'h10000,0, 1, 0, 0, 14'h0,    16'h0,    NOP,      0, 0);
    add("oor_stalled",   17'h10000,1, 0, 0, 0, 14'h0,    16'h0,    NOP,      0, 0);
    add("oor_fetch",     17'h10000,0, 0, 0, 0, 14'h0,    16'h0,    NOP,      0, 1);
    add("err_sticky",    17'h0,    0, 0, 0, 0, 14'h0,    16'h0,    16'h1111, 1, 1);
    add("oor_4000",      17'h4000, 0, 0, 0, 0, 14'h0,    16'h0,    NOP,      0, 1);
    add("fetch1c",       17'h1,    0, 0, 0, 0, 14'h0,    16'h0,    16'h2222, 1, 1);
    add("run_to_load",   17'h1,    0, 0, 1, 0, 14'h0,    16'h0,    NOP,      0, 1);
    add("load_w5",       17'h1,    0, 0, 1, 1, 14'h5,    16'hABCD, NOP,      0, 1);
    add("exit_we_ign",   17'h1,    0, 0, 0, 1, 14'h5,    16'hDEAD, NOP,      0, 1);
    add("boot_nop2",     17'h5,    0, 0, 0, 0, 14'h0,    16'h0,    NOP,      0, 1);
    add("fetch5",        17'h5,    0, 0, 0, 0, 14'h0,    16'h0,    16'hABCD, 1, 1);
    add("run_we_ign",    17'h5,    0, 0, 0, 1, 14'h5,    16'h1234, 16'hABCD, 1, 1);
    add("mem5_kept",     17'h5,    0, 0, 0, 0, 14'h0,    16'h0,    16'hABCD, 1, 1);

    rst_n = 1'b0;
    drive(17'h0, 0, 0, 0, 0, 14'h0, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_values", NOP, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].pc, vecs[i].stall, vecs[i].flow, vecs[i].pm, vecs[i].we,
            vecs[i].addr, vecs[i].data);
      @(posedge clk);
      #1;
      chk(vecs[i].name, vecs[i].exp_instr, vecs[i].exp_vld, vecs[i].exp_err);
    end

    // Reset asserted mid-stall: outputs must clear without waiting for a clock edge.
    drive(17'h5, 1, 0, 0, 0, 14'h0, 16'h0);
    @(posedge clk);
    #1;
    chk("pre_reset_hold", 16'hABCD, 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", NOP, 0, 0);
    @(posedge clk);
    #1;
    chk("reset_held", NOP, 0, 0);

    // Memory survives reset: one BOOT NOP, then the preloaded words in order.
    drive(17'h0, 0, 0, 0, 0, 14'h0, 16'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pc = (i == 0) ? 17'h0 : 17'(i - 1);
      @(posedge clk);
      #1;
      chk($sformatf("reboot_seq%0d", i), rel_exp[i], rel_vld[i], 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
